wb_pipe_reg: RTL and testbench

//  Parametrised MEM/WB pipeline register, successor to the fixed 3-signal WB latch.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_retire_cnt.sv | 23 ++
 rtl/wb_pipe_reg.sv | 94 +++++++++
 tb/tb_wb_pipe_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB pipeline register: default widths and
// write-back source select encodings.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_RA_W   = 5;
    localparam int WB_MUX_W  = 2;
    localparam int WB_CNT_W  = 32;

    typedef enum logic [WB_MUX_W-1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/wb_retire_cnt.sv
// Saturating retired-instruction counter; holds at all-ones instead of wrapping.
module wb_retire_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic at_max;

    assign at_max = (cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with stall/flush, bubble gating, forwarding
// compares for the EX-stage bypass and a retired-instruction counter.
module wb_pipe_reg
    import wb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int RA_W     = WB_RA_W,
    parameter int MUX_W    = WB_MUX_W,
    parameter int CNT_W    = WB_CNT_W,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              VALID_IN,
    input  logic              RF_WE_IN,
    input  logic [RA_W-1:0]   RF_WA_IN,
    input  logic [DATA_W-1:0] WDATA_IN,
    input  logic [MUX_W-1:0]  MREWR_MUX_IN,
    input  logic              NUMINSTADD_IN,
    input  logic [RA_W-1:0]   RA_A,
    input  logic [RA_W-1:0]   RA_B,
    output logic              VALID_OUT,
    output logic              RF_WE_OUT,
    output logic [RA_W-1:0]   RF_WA_OUT,
    output logic [DATA_W-1:0] WDATA_OUT,
    output logic [MUX_W-1:0]  MREWR_MUX_OUT,
    output logic              NUMINSTADD_OUT,
    output logic              FWD_A,
    output logic              FWD_B,
    output logic [CNT_W-1:0]  NUM_INST
);

    logic              valid_q;
    logic              we_q;
    logic              nia_q;
    logic [RA_W-1:0]   wa_q;
    logic [DATA_W-1:0] data_q;
    logic [MUX_W-1:0]  mux_q;
    logic              wa_is_zero;
    logic              retire_en;

    // FLUSH outranks STALL so a stalled slot can still be squashed.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            nia_q   <= 1'b0;
            wa_q    <= '0;
            data_q  <= '0;
            mux_q   <= '0;
        end else if (FLUSH) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            nia_q   <= 1'b0;
            wa_q    <= '0;
            data_q  <= '0;
            mux_q   <= '0;
        end else if (!STALL) begin
            valid_q <= VALID_IN;
            we_q    <= RF_WE_IN;
            nia_q   <= NUMINSTADD_IN;
            wa_q    <= RF_WA_IN;
            data_q  <= WDATA_IN;
            mux_q   <= MREWR_MUX_IN;
        end
    end

    assign VALID_OUT      = valid_q;
    assign RF_WE_OUT      = valid_q & we_q;
    assign NUMINSTADD_OUT = valid_q & nia_q;
    assign RF_WA_OUT      = wa_q;
    assign WDATA_OUT      = data_q;
    assign MREWR_MUX_OUT  = mux_q;

    assign wa_is_zero = (ZERO_REG != 0) && (wa_q == '0);
    assign FWD_A      = RF_WE_OUT & (RA_A == wa_q) & ~wa_is_zero;
    assign FWD_B      = RF_WE_OUT & (RA_B == wa_q) & ~wa_is_zero;

    // The instruction retires on the edge it leaves the stage, so a long
    // stall still counts it exactly once.
    assign retire_en = NUMINSTADD_OUT & ~STALL;

    wb_retire_cnt #(
        .CNT_W (CNT_W)
    ) u_retire_cnt (
        .clk   (CLK),
        .rst_n (RSTn),
        .en    (retire_en),
        .cnt   (NUM_INST)
    );

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: directed scenarios then random traffic, checked
// against a slot-level reference model.
module tb_wb_pipe_reg;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, valid_in, we_in, nia_in;
    logic [4:0]  wa_in, ra_a, ra_b;
    logic [31:0] data_in;
    logic [1:0]  mux_in;

    logic        o_valid, o_we, o_nia, o_fa, o_fb;
    logic [4:0]  o_wa;
    logic [31:0] o_data, o_cnt;
    logic [1:0]  o_mux;

    logic        z_valid, z_we, z_nia, z_fa, z_fb;
    logic [4:0]  z_wa;
    logic [31:0] z_data, z_cnt;
    logic [1:0]  z_mux;

    logic        c_valid, c_we, c_nia, c_fa, c_fb;
    logic [4:0]  c_wa;
    logic [31:0] c_data;
    logic [1:0]  c_mux;
    logic [3:0]  c_cnt;

    int total = 0;
    int bad   = 0;

    // reference model: the instruction currently held and the retired totals
    bit          m_valid, m_we, m_nia;
    logic [4:0]  m_wa;
    logic [31:0] m_data;
    logic [1:0]  m_mux;
    longint      m_cnt, m_cnt4;

    always #5 clk = ~clk;

    wb_pipe_reg dut (
        .CLK(clk), .RSTn(rst_n), .STALL(stall), .FLUSH(flush),
        .VALID_IN(valid_in), .RF_WE_IN(we_in), .RF_WA_IN(wa_in), .WDATA_IN(data_in),
        .MREWR_MUX_IN(mux_in), .NUMINSTADD_IN(nia_in), .RA_A(ra_a), .RA_B(ra_b),
        .VALID_OUT(o_valid), .RF_WE_OUT(o_we), .RF_WA_OUT(o_wa), .WDATA_OUT(o_data),
        .MREWR_MUX_OUT(o_mux), .NUMINSTADD_OUT(o_nia), .FWD_A(o_fa), .FWD_B(o_fb),
        .NUM_INST(o_cnt));

    wb_pipe_reg #(.ZERO_REG(0)) dut_z0 (
        .CLK(clk), .RSTn(rst_n), .STALL(stall), .FLUSH(flush),
        .VALID_IN(valid_in), .RF_WE_IN(we_in), .RF_WA_IN(wa_in), .WDATA_IN(data_in),
        .MREWR_MUX_IN(mux_in), .NUMINSTADD_IN(nia_in), .RA_A(ra_a), .RA_B(ra_b),
        .VALID_OUT(z_valid), .RF_WE_OUT(z_we), .RF_WA_OUT(z_wa), .WDATA_OUT(z_data),
        .MREWR_MUX_OUT(z_mux), .NUMINSTADD_OUT(z_nia), .FWD_A(z_fa), .FWD_B(z_fb),
        .NUM_INST(z_cnt));

    wb_pipe_reg #(.CNT_W(4)) dut_c4 (
        .CLK(clk), .RSTn(rst_n), .STALL(stall), .FLUSH(flush),
        .VALID_IN(valid_in), .RF_WE_IN(we_in), .RF_WA_IN(wa_in), .WDATA_IN(data_in),
        .MREWR_MUX_IN(mux_in), .NUMINSTADD_IN(nia_in), .RA_A(ra_a), .RA_B(ra_b),
        .VALID_OUT(c_valid), .RF_WE_OUT(c_we), .RF_WA_OUT(c_wa), .WDATA_OUT(c_data),
        .MREWR_MUX_OUT(c_mux), .NUMINSTADD_OUT(c_nia), .FWD_A(c_fa), .FWD_B(c_fb),
        .NUM_INST(c_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_fwd(input logic [4:0] ra, input bit zero_reg);
        return m_valid && m_we && (ra == m_wa) && !(zero_reg && m_wa == 5'd0);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_nia = 0;
        m_wa = '0; m_data = '0; m_mux = '0;
        m_cnt = 0; m_cnt4 = 0;
    endtask

    // Advance the model by one edge using the inputs presently applied.
    task automatic model_edge();
        if (m_valid && m_nia && !stall) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (flush) begin
            m_valid = 0; m_we = 0; m_nia = 0;
            m_wa = '0; m_data = '0; m_mux = '0;
        end else if (!stall) begin
            m_valid = valid_in; m_we = we_in; m_nia = nia_in;
            m_wa = wa_in; m_data = data_in; m_mux = mux_in;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
        chk({tag, ".rf_we"}, 64'(o_we),    64'(m_valid & m_we));
        chk({tag, ".wa"},    64'(o_wa),    64'(m_wa));
        chk({tag, ".data"},  64'(o_data),  64'(m_data));
        chk({tag, ".mux"},   64'(o_mux),   64'(m_mux));
        chk({tag, ".nia"},   64'(o_nia),   64'(m_valid & m_nia));
        chk({tag, ".fwd_a"}, 64'(o_fa),    64'(exp_fwd(ra_a, 1'b1)));
        chk({tag, ".fwd_b"}, 64'(o_fb),    64'(exp_fwd(ra_b, 1'b1)));
        chk({tag, ".cnt"},   64'(o_cnt),   64'(m_cnt));
        chk({tag, ".z0_fwd_a"}, 64'(z_fa), 64'(exp_fwd(ra_a, 1'b0)));
        chk({tag, ".z0_fwd_b"}, 64'(z_fb), 64'(exp_fwd(ra_b, 1'b0)));
        chk({tag, ".c4_cnt"},   64'(c_cnt), 64'(m_cnt4));
    endtask

    task automatic drive(input bit v, input bit we, input logic [4:0] wa,
                         input logic [31:0] d, input logic [1:0] mx, input bit nia);
        valid_in = v; we_in = we; wa_in = wa; data_in = d; mux_in = mx; nia_in = nia;
    endtask

    // Assert reset a few ns into the cycle, check, and release before the next edge.
    task automatic mid_cycle_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 0; flush = 0;
        drive(0, 0, '0, '0, '0, 0);
        ra_a = '0; ra_b = '0;
        model_reset();
        #2;
        check_all("reset_init");
        #10;
        rst_n = 1'b1;

        // load and forwarding compare
        drive(1, 1, 5'd5, 32'hDEADBEEF, WB_SEL_MEM, 0);
        ra_a = 5'd5; ra_b = 5'd6;
        tick();
        check_all("load");
        chk("load.fwd_a_one", 64'(o_fa), 64'd1);

        // stall holds and counts a retiring instruction only once
        drive(1, 1, 5'd9, 32'h1234_5678, WB_SEL_PC4, 1);
        tick();
        check_all("stall_load");
        drive(1, 0, 5'd3, 32'hCAFE_0000, WB_SEL_ALU, 1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("stall_hold");
        end
        stall = 0;
        tick();
        check_all("stall_release");
        chk("stall_release.cnt_one", 64'(o_cnt), 64'd1);

        // flush over a departing valid instruction
        drive(1, 1, 5'd3, 32'hAAAA_5555, WB_SEL_MEM, 1);
        ra_a = 5'd3; ra_b = 5'd3;
        tick();
        flush = 1;
        tick();
        check_all("flush");
        flush = 0;

        // stall and flush together squash without counting
        drive(1, 1, 5'd7, 32'h0BAD_F00D, WB_SEL_ALU, 1);
        tick();
        stall = 1; flush = 1;
        tick();
        check_all("stall_flush");
        stall = 0; flush = 0;

        // register zero forwarding
        drive(1, 1, 5'd0, 32'h0000_0042, WB_SEL_ALU, 0);
        ra_a = 5'd0; ra_b = 5'd1;
        tick();
        check_all("zero_reg");

        // reset during a stall clears the counter
        drive(1, 1, 5'd4, 32'h7777_0000, WB_SEL_MEM, 1);
        tick();
        stall = 1;
        tick();
        mid_cycle_reset("reset_mid_stall");
        stall = 0;

        // saturation of the narrow counter
        for (int i = 0; i < 20; i++) begin
            drive(1, $urandom_range(0, 1), 5'($urandom_range(1, 31)), $urandom, 2'($urandom_range(0, 2)), 1);
            tick();
        end
        tick();
        check_all("saturate");
        chk("saturate.c4_full", 64'(c_cnt), 64'hF);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  $urandom, 2'($urandom_range(0, 2)), $urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            ra_a = 5'($urandom_range(0, 7));
            ra_b = 5'($urandom_range(0, 7));
            tick();
            check_all("random");
            if (i == 200) mid_cycle_reset("reset_mid_random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
